// File: rtl/bmi_alu_sequencer.sv
// Round-robin front end that shares one bit-manipulation ALU between two requesters.
// Define BMI_SEQ_STATS_EN to add saturating grant/busy statistics outputs.
module bmi_alu_sequencer #(
   parameter int DATA_WIDTH  = 256,
   parameter int ALU_LATENCY = 1,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef BMI_SEQ_STATS_EN
   output logic [CNT_WIDTH-1:0]  stat_grant0,
   output logic [CNT_WIDTH-1:0]  stat_grant1,
   output logic [CNT_WIDTH-1:0]  stat_busy,
`endif
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [1:0]            req0_opcode,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [1:0]            req1_opcode,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   output logic                  alu_start,
   output logic [1:0]            alu_opcode,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   input  logic [DATA_WIDTH-1:0] alu_result,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic [DATA_WIDTH-1:0] rsp_data
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  alu_start_q, alu_start_d;
   logic [1:0]            alu_opcode_q, alu_opcode_d;
   logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
   logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_id_q, rsp_id_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  grant0, grant1;

   // Requester 1 wins when alone, or under contention when requester 0 was served last.
   assign grant1 = req1_valid && (!req0_valid || !last_grant_q);
   assign grant0 = req0_valid && !grant1;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      alu_start_d  = 1'b0;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      case (state_q)
         IDLE: begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (grant0 || grant1) begin
               alu_opcode_d = grant1 ? req1_opcode : req0_opcode;
               alu_a_d      = grant1 ? req1_a : req0_a;
               alu_b_d      = grant1 ? req1_b : req0_b;
               rsp_id_d     = grant1;
               last_grant_d = grant1;
               cnt_d        = CNT_WIDTH'(ALU_LATENCY);
               alu_start_d  = 1'b1;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(1)) begin
               rsp_data_d  = alu_result;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         alu_start_q  <= 1'b0;
         alu_opcode_q <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         alu_start_q  <= alu_start_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   assign alu_start  = alu_start_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;

`ifdef BMI_SEQ_STATS_EN
   logic [CNT_WIDTH-1:0] stat_grant0_q, stat_grant0_d;
   logic [CNT_WIDTH-1:0] stat_grant1_q, stat_grant1_d;
   logic [CNT_WIDTH-1:0] stat_busy_q, stat_busy_d;

   // Counters stick at all-ones instead of wrapping.
   always_comb begin
      stat_grant0_d = stat_grant0_q;
      stat_grant1_d = stat_grant1_q;
      stat_busy_d   = stat_busy_q;
      if (req0_ready && req0_valid && (stat_grant0_q != '1))
         stat_grant0_d = stat_grant0_q + CNT_WIDTH'(1);
      if (req1_ready && req1_valid && (stat_grant1_q != '1))
         stat_grant1_d = stat_grant1_q + CNT_WIDTH'(1);
      if ((state_q == EXEC) && (stat_busy_q != '1))
         stat_busy_d = stat_busy_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_grant0_q <= '0;
         stat_grant1_q <= '0;
         stat_busy_q   <= '0;
      end else begin
         stat_grant0_q <= stat_grant0_d;
         stat_grant1_q <= stat_grant1_d;
         stat_busy_q   <= stat_busy_d;
      end
   end

   assign stat_grant0 = stat_grant0_q;
   assign stat_grant1 = stat_grant1_q;
   assign stat_busy   = stat_busy_q;
`endif

endmodule

// File: tb/tb_bmi_alu_sequencer.sv
// Directed bench for bmi_alu_sequencer: a transaction-level model is compared against the
// DUT every cycle, and hand-computed literals pin the main scenarios.
module tb_bmi_alu_sequencer;

   localparam int DW  = 256;
   localparam int LAT = 2;
   localparam int CW  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]    req0_opcode, req1_opcode;
   logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
   logic          alu_start;
   logic [1:0]    alu_opcode;
   logic [DW-1:0] alu_a, alu_b, alu_result;
   logic          rsp_valid, rsp_ready, rsp_id;
   logic [DW-1:0] rsp_data;
`ifdef BMI_SEQ_STATS_EN
   logic [CW-1:0] stat_grant0, stat_grant1, stat_busy;
`endif

   int checks = 0;
   int errors = 0;

   // Model state: one operation in flight, aged in cycles since acceptance.
   bit            mBusy = 1'b0;
   int            mAge = 0;
   int            mId = 0;
   int            mLast = 1;
   logic [1:0]    mOp = '0;
   logic [DW-1:0] mA = '0;
   logic [DW-1:0] mB = '0;
   int            mG0 = 0;
   int            mG1 = 0;
   int            mBusyCnt = 0;

   int            aluAge = 0;
   logic          aluReady;

   always #5 clk = ~clk;

   bmi_alu_sequencer #(.DATA_WIDTH(DW), .ALU_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
`ifdef BMI_SEQ_STATS_EN
      .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_busy(stat_busy),
`endif
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
   );

   function automatic logic [DW-1:0] aluFn(logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
      int n;
      n = int'(b[7:0]);
      case (op)
         2'd0:    return {{(DW-1){1'b0}}, ^a};
         2'd1:    return (a >> n) | (a << (DW - n));
         2'd2:    return (a << n) | (a >> (DW - n));
         default: return DW'($countones(a));
      endcase
   endfunction

   // ALU stand-in: the result is only correct LAT cycles after alu_start, garbage before.
   always @(posedge clk) begin
      if (alu_start) aluAge <= 1;
      else if (aluAge != 0) aluAge <= aluAge + 1;
   end
   assign aluReady   = (alu_start || (aluAge != 0)) && ((alu_start ? 0 : aluAge) >= LAT - 1);
   assign alu_result = aluReady ? aluFn(alu_opcode, alu_a, alu_b) : ~aluFn(alu_opcode, alu_a, alu_b);

   function automatic int arbitrate(logic v0, logic v1, int last);
      if (v0 && v1) return (last == 1) ? 0 : 1;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   function automatic int sat(int x);
      return (x > 255) ? 255 : x;
   endfunction

   task automatic checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, want);
      end
   endtask

   task automatic modelCompare();
      int g;
      if (rst) begin
         mBusy = 1'b0; mAge = 0; mLast = 1; mG0 = 0; mG1 = 0; mBusyCnt = 0;
         checkOutput("rst alu_start", alu_start, 0);
         checkOutput("rst alu_a", alu_a, 0);
         checkOutput("rst rsp_valid", rsp_valid, 0);
         checkOutput("rst rsp_data", rsp_data, 0);
`ifdef BMI_SEQ_STATS_EN
         checkOutput("rst stat_busy", stat_busy, 0);
`endif
         return;
      end
      g = mBusy ? -1 : arbitrate(req0_valid, req1_valid, mLast);
      checkOutput("model req0_ready", req0_ready, g == 0);
      checkOutput("model req1_ready", req1_ready, g == 1);
      checkOutput("model alu_start", alu_start, mBusy && (mAge == 1));
      checkOutput("model rsp_valid", rsp_valid, mBusy && (mAge == LAT + 1));
      if (mBusy && mAge <= LAT) begin
         checkOutput("model alu_opcode", alu_opcode, mOp);
         checkOutput("model alu_a", alu_a, mA);
         checkOutput("model alu_b", alu_b, mB);
      end
      if (mBusy && mAge == LAT + 1) begin
         checkOutput("model rsp_id", rsp_id, mId[0]);
         checkOutput("model rsp_data", rsp_data, aluFn(mOp, mA, mB));
      end
`ifdef BMI_SEQ_STATS_EN
      checkOutput("model stat_grant0", stat_grant0, mG0);
      checkOutput("model stat_grant1", stat_grant1, mG1);
      checkOutput("model stat_busy", stat_busy, mBusyCnt);
`endif
      if (!mBusy) begin
         if (g >= 0) begin
            mBusy = 1'b1; mAge = 1; mId = g; mLast = g;
            mOp = (g == 1) ? req1_opcode : req0_opcode;
            mA  = (g == 1) ? req1_a : req0_a;
            mB  = (g == 1) ? req1_b : req0_b;
            if (g == 0) mG0 = sat(mG0 + 1);
            else mG1 = sat(mG1 + 1);
         end
      end else if (mAge <= LAT) begin
         mBusyCnt = sat(mBusyCnt + 1);
         mAge++;
      end else if (rsp_ready) begin
         mBusy = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      modelCompare();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(logic v0, logic [1:0] op0, logic [DW-1:0] a0, logic [DW-1:0] b0,
                                logic v1, logic [1:0] op1, logic [DW-1:0] a1, logic [DW-1:0] b1,
                                logic rr);
      req0_valid = v0; req0_opcode = op0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_opcode = op1; req1_a = a1; req1_b = b1;
      rsp_ready = rr;
      #1;
   endtask

   task automatic idleInputs(logic rr);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, rr);
   endtask

   task automatic waitRsp();
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid) return;
         tick();
      end
      checkOutput("rsp_valid timeout", rsp_valid, 1);
   endtask

   task automatic runOp(int who, logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
      bit got;
      got = 1'b0;
      applyStimulus(who == 0, op, a, b, who == 1, op, a, b, 1);
      for (int i = 0; i < 20 && !got; i++) begin
         if ((who == 0) ? req0_ready : req1_ready) got = 1'b1;
         else tick();
      end
      if (!got) checkOutput("ready timeout", 0, 1);
      tick();
      idleInputs(1);
      waitRsp();
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [DW-1:0] topBit;
      int order[6];
      int ng;
      topBit = '0;
      topBit[DW-1] = 1'b1;

      rst = 1'b1;
      idleInputs(0);
      tick();
      tick();
      checkOutput("reset rsp_valid", rsp_valid, 0);
      checkOutput("reset alu_start", alu_start, 0);
      rst = 1'b0;

      // Single request: PARITY of 0x7 is 1.
      applyStimulus(1, 2'd0, 7, 0, 0, 0, 0, 0, 1);
      checkOutput("single req0_ready", req0_ready, 1);
      checkOutput("single req1_ready", req1_ready, 0);
      tick();
      idleInputs(1);
      checkOutput("single alu_start", alu_start, 1);
      checkOutput("single alu_a", alu_a, 7);
      tick();
      checkOutput("single alu_start drop", alu_start, 0);
      checkOutput("single early rsp_valid", rsp_valid, 0);
      tick();
      checkOutput("single rsp_valid", rsp_valid, 1);
      checkOutput("single rsp_id", rsp_id, 0);
      checkOutput("single rsp_data", rsp_data, 1);
      tick();
      checkOutput("single rsp cleared", rsp_valid, 0);

      // Backpressure: req1 ROTR 1 by 1 gives the top bit; req0 waits meanwhile.
      applyStimulus(0, 0, 0, 0, 1, 2'd1, 1, 1, 0);
      checkOutput("bp req1_ready", req1_ready, 1);
      tick();
      applyStimulus(1, 2'd2, 1, 4, 0, 0, 0, 0, 0);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp rsp_valid", rsp_valid, 1);
         checkOutput("bp rsp_data", rsp_data, topBit);
         checkOutput("bp rsp_id", rsp_id, 1);
         checkOutput("bp req0_ready", req0_ready, 0);
         checkOutput("bp req1_ready", req1_ready, 0);
         tick();
      end
      applyStimulus(1, 2'd2, 1, 4, 0, 0, 0, 0, 1);
      checkOutput("bp handshake rsp_valid", rsp_valid, 1);
      tick();
      checkOutput("bp released rsp_valid", rsp_valid, 0);
      checkOutput("bp idle req0_ready", req0_ready, 1);

      // Latency: the ROTL 1 by 4 accepted above returns 0x10 exactly LAT+1 cycles later.
      tick();
      idleInputs(1);
      for (int k = 0; k < LAT; k++) begin
         checkOutput("lat alu_start", alu_start, k == 0);
         checkOutput("lat alu_opcode", alu_opcode, 2);
         checkOutput("lat alu_a", alu_a, 1);
         checkOutput("lat alu_b", alu_b, 4);
         checkOutput("lat rsp_valid early", rsp_valid, 0);
         tick();
      end
      checkOutput("lat rsp_valid", rsp_valid, 1);
      checkOutput("lat rsp_data", rsp_data, 'h10);
      checkOutput("lat rsp_id", rsp_id, 0);
      tick();

      // Reset during the second EXEC cycle drops the operation.
      applyStimulus(0, 0, 0, 0, 1, 2'd0, 3, 0, 1);
      checkOutput("rstx req1_ready", req1_ready, 1);
      tick();
      idleInputs(1);
      tick();
      rst = 1'b1;
      #1;
      checkOutput("rstx alu_start", alu_start, 0);
      checkOutput("rstx alu_a", alu_a, 0);
      checkOutput("rstx rsp_id", rsp_id, 0);
      checkOutput("rstx rsp_data", rsp_data, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("rstx no rsp", rsp_valid, 0);
         tick();
      end

      // Contention: requester 0 first after reset, then strict alternation.
      applyStimulus(1, 2'd1, 'hF0, 4, 1, 2'd3, 'hFF, 0, 1);
      ng = 0;
      for (int c = 0; c < 80 && ng < 6; c++) begin
         if (req0_ready) begin order[ng] = 0; ng++; end
         else if (req1_ready) begin order[ng] = 1; ng++; end
         tick();
      end
      checkOutput("contention grant count", ng, 6);
      for (int i = 0; i < 6; i++) checkOutput($sformatf("grant order %0d", i), order[i], i % 2);
      idleInputs(1);
      for (int i = 0; i < LAT + 3; i++) tick();

      // Stats: 4 ops from requester 1, 2 from requester 0, after a fresh reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      runOp(1, 2'd3, 'hF, 0);
      runOp(1, 2'd1, 'h100, 8);
      runOp(0, 2'd2, 'h3, 2);
      runOp(1, 2'd0, 'h1, 0);
      runOp(0, 2'd3, 'hFFFF, 0);
      runOp(1, 2'd2, topBit, 1);
      tick();
`ifdef BMI_SEQ_STATS_EN
      checkOutput("stat_grant1", stat_grant1, 4);
      checkOutput("stat_grant0", stat_grant0, 2);
      checkOutput("stat_busy", stat_busy, 12);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
